// File: rtl/twos_comp_scheduler.sv
// Round-robin front end feeding one bit-serial two's-complement negation engine.
// A result is held with its requester index until the consumer takes it.
module twos_comp_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_ovf,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester transfers on the edge where req_valid[i] && req_ready[i];
  // a result transfers on the edge where out_valid && out_ready. Neither valid
  // waits on its ready, and ready without valid is ignored.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;

  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] grant_op;
  logic             serial_bit;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign grant_op   = req_data[grant_id*WIDTH +: WIDTH];
  assign req_ready  = (state_q == S_IDLE && grant_any) ? (NREQ'(1) << grant_id) : '0;
  assign serial_bit = seen_q ? ~sr_q[0] : sr_q[0];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    sr_d       = sr_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    seen_d     = seen_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          sr_d       = grant_op;
          id_d       = grant_id;
          cnt_d      = '0;
          seen_d     = 1'b0;
          ovf_pend_d = (grant_op == {1'b1, {(WIDTH-1){1'b0}}});
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Bits below and including the first 1 pass through; the rest invert.
        res_d  = {serial_bit, res_q[WIDTH-1:1]};
        sr_d   = sr_q >> 1;
        seen_d = seen_q | sr_q[0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = S_DONE;
          ovf_d   = ovf_pend_q;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d  = S_IDLE;
          rr_ptr_d = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      sr_q       <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      sr_q       <= sr_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out_data  = res_q;
  assign out_id    = id_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_twos_comp_scheduler.sv
// Directed and randomized checks of twos_comp_scheduler against an arithmetic
// model of negation and rotating-priority arbitration.
module tb_twos_comp_scheduler;

  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*W-1:0]    req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic [IDW-1:0]       out_id;
  logic                 out_ovf;
  logic                 out_ready;
  logic                 busy;
  logic [1:0]           dbg_state;

  twos_comp_scheduler #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ovf   (out_ovf),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model state
  logic [W-1:0] ops [NREQ];
  int           m_ptr;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = ops[i];
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] vmask);
    for (int k = 0; k < NREQ; k++) begin
      if (vmask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    step();
    step();
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  // One full transaction starting at a negedge in IDLE.
  task automatic run_one(input logic [NREQ-1:0] vmask, input int stall, input bit noise,
                         output int gid);
    int           g;
    logic [W-1:0] exp_res;
    logic         exp_ovf;
    logic [W-1:0] got;
    req_valid = vmask;
    drive_ops();
    #1;
    g = model_grant(vmask);
    gid = g;
    check("grant", 32'(req_ready), 32'(1 << g));
    exp_res = W'((1 << W) - int'(ops[g]));
    exp_ovf = (int'(ops[g]) == (1 << (W-1)));
    exp_q.push_back(exp_res);
    step();
    for (int k = 0; k < W; k++) begin
      check("shift_busy", 32'(busy), 32'd1);
      check("shift_valid", 32'(out_valid), 32'd0);
      check("shift_ready", 32'(req_ready), 32'd0);
      if (noise) begin
        req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      step();
    end
    got = exp_q.pop_front();
    check("done_valid", 32'(out_valid), 32'd1);
    check("done_data", 32'(out_data), 32'(got));
    check("done_id", 32'(out_id), 32'(g));
    check("done_ovf", 32'(out_ovf), 32'(exp_ovf));
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      if (noise) req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(got));
      check("stall_id", 32'(out_id), 32'(g));
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    m_ptr = (g + 1) % NREQ;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int gid;
    for (int i = 0; i < NREQ; i++) ops[i] = '0;
    req_data = '0;

    // reset values
    do_reset();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // single request, operand 0011 -> 1101
    ops[0] = 4'b0011;
    run_one(4'b0001, 0, 1'b0, gid);

    // full sweep on requester 2
    for (int x = 0; x < (1 << W); x++) begin
      ops[2] = W'(x);
      run_one(4'b0100, 0, 1'b0, gid);
    end

    // round-robin with all requesters valid
    do_reset();
    ops[0] = 4'b0001; ops[1] = 4'b0010; ops[2] = 4'b0100; ops[3] = 4'b0111;
    for (int n = 0; n < 5; n++) run_one(4'b1111, 0, 1'b0, gid);

    // back-pressure, then immediate next grant
    ops[1] = 4'b0101;
    run_one(4'b0010, 10, 1'b0, gid);
    run_one(4'b1111, 0, 1'b0, gid);

    // pointer skip: ptr=1 with 1001 grants 3 then 0
    do_reset();
    ops[0] = 4'b0110; ops[3] = 4'b1000;
    run_one(4'b0001, 0, 1'b0, gid);
    run_one(4'b1001, 0, 1'b0, gid);
    run_one(4'b1001, 0, 1'b0, gid);

    // reset on the second SHIFT cycle
    run_one(4'b0010, 0, 1'b0, gid);
    ops[2] = 4'b0011;
    req_valid = 4'b1111;
    drive_ops();
    #1;
    check("mid_grant", 32'(req_ready), 32'(1 << model_grant(4'b1111)));
    step();
    step();
    rst = 1'b1;
    step();
    rst   = 1'b0;
    m_ptr = 0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_data", 32'(out_data), 32'd0);
    check("mid_ready", 32'(req_ready), 32'b0001);
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < W + 2; c++) begin
      step();
      check("mid_no_stale", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    exp_q.delete();

    // randomized traffic with noise on unrelated inputs
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) ops[i] = W'($urandom_range(0, (1 << W) - 1));
      run_one(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 3), 1'b1, gid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
